control_sequencer: RTL

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/control_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle control sequencer for a small MIPS-like datapath.
// Walks each instruction through FETCH, FWAIT, DECODE, EXEC and then, as the
// opcode requires, MEM, MWAIT and WB. It drives the datapath control strobes
// and counts retired instructions.
//
// Parameters
//   MEM_LAT    BRAM read latency in cycles (1..3)
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   run              level enable; a new fetch starts only while high
//   opcode, func     decoder fields, valid from DECODE onward
//   regDst..lblSel   datapath controls, all 0 outside the states that use them
//   pcWrite          PC update strobe; one pulse per retired instruction
//   irWrite          instruction register load, in the last FWAIT cycle
//   halted, illegal  HALT state flag; HALT was entered on an undefined opcode
//   instrCount       retired-instruction counter, wraps at 16 bits
//   dbg_state        current FSM state, for observation only
//
// Handshake: there is none. run is sampled in IDLE and at retirement. The
// opcode and func fields are captured once, in DECODE.
module control_sequencer #(
  parameter int MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [5:0]  opcode,
  input  logic [4:0]  func,
  output logic [1:0]  regDst,
  output logic        regWrite,
  output logic        memRead,
  output logic        memWrite,
  output logic [1:0]  memToReg,
  output logic        ALUsrc,
  output logic [4:0]  ALUop,
  output logic        ALUsel,
  output logic        branch,
  output logic        jumpAddr,
  output logic        lblSel,
  output logic        pcWrite,
  output logic        irWrite,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] instrCount,
  output logic [3:0]  dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_FWAIT, S_DECODE, S_EXEC, S_MEM, S_MWAIT, S_WB, S_HALT
  } state_t;

  localparam logic [5:0] OP_RALU = 6'd0;
  localparam logic [5:0] OP_IALU = 6'd1;
  localparam logic [5:0] OP_LW   = 6'd2;
  localparam logic [5:0] OP_SW   = 6'd3;
  localparam logic [5:0] OP_BR   = 6'd4;
  localparam logic [5:0] OP_J    = 6'd5;
  localparam logic [5:0] OP_JAL  = 6'd6;
  localparam logic [5:0] OP_JR   = 6'd7;
  localparam logic [5:0] OP_HALT = 6'd63;

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [5:0]  op_q;
  logic [4:0]  fn_q;
  logic [15:0] count_q;
  logic        illegal_q, illegal_d;
  logic        dec_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      fn_q      <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      if (dec_load) begin
        op_q <= opcode;
        fn_q <= func;
      end
      if (pcWrite) count_q <= count_q + 16'd1;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    illegal_d = illegal_q;
    dec_load  = 1'b0;
    regDst    = 2'd0;
    regWrite  = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    memToReg  = 2'd0;
    ALUsrc    = 1'b0;
    ALUop     = 5'd0;
    ALUsel    = 1'b0;
    branch    = 1'b0;
    jumpAddr  = 1'b0;
    lblSel    = 1'b0;
    pcWrite   = 1'b0;
    irWrite   = 1'b0;

    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: state_d = S_FWAIT;
      S_FWAIT: begin
        if (cnt_q == LAT - 3'd1) begin
          irWrite = 1'b1;
          state_d = S_DECODE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      S_DECODE: begin
        dec_load = 1'b1;
        if (opcode <= OP_JR) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_HALT;
          illegal_d = (opcode != OP_HALT);
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_RALU, OP_IALU: begin
            ALUop   = fn_q;
            ALUsrc  = (op_q == OP_IALU);
            ALUsel  = (op_q == OP_RALU) & fn_q[4];
            state_d = S_WB;
          end
          OP_LW, OP_SW: begin
            ALUsrc  = 1'b1;
            state_d = S_MEM;
          end
          OP_BR: begin
            branch  = 1'b1;
            lblSel  = 1'b1;
            pcWrite = 1'b1;
          end
          OP_J: begin
            lblSel  = 1'b1;
            pcWrite = 1'b1;
          end
          OP_JR: begin
            jumpAddr = 1'b1;
            pcWrite  = 1'b1;
          end
          OP_JAL: begin
            // r31 captures PC+4 on the same edge that loads the label.
            lblSel   = 1'b1;
            pcWrite  = 1'b1;
            regWrite = 1'b1;
            regDst   = 2'd2;
            memToReg = 2'd2;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        memRead  = (op_q == OP_LW);
        memWrite = (op_q == OP_SW);
        state_d  = S_MWAIT;
      end
      S_MWAIT: begin
        if (op_q == OP_LW) begin
          // LW spends one extra MWAIT cycle with memRead low.
          // That cycle lets the data from the last read request arrive
          // before WB selects it.
          memRead = (cnt_q < LAT);
          if (cnt_q == LAT) state_d = S_WB;
          else cnt_d = cnt_q + 3'd1;
        end else begin
          memWrite = 1'b1;
          if (cnt_q == LAT - 3'd1) pcWrite = 1'b1;
          else cnt_d = cnt_q + 3'd1;
        end
      end
      S_WB: begin
        regWrite = 1'b1;
        pcWrite  = 1'b1;
        regDst   = (op_q == OP_RALU) ? 2'd1 : 2'd0;
        memToReg = (op_q == OP_LW) ? 2'd1 : 2'd0;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase

    // Every retirement (the pcWrite cycle) decides between refetch and idle.
    if (pcWrite) state_d = run ? S_FETCH : S_IDLE;
  end

  assign halted     = (state_q == S_HALT);
  assign illegal    = illegal_q;
  assign instrCount = count_q;
  assign dbg_state  = state_q;

endmodule
